// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer FSM encodings and the op codes the decoder
// uses to drive the add/subtract select.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  // Decoder helper: subtract select for a given op code
  function automatic logic op_is_sub(input alu_op_e op);
    return op == OP_SUB;
  endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Operand request / result response handshake bundle for mp_add_seq.
interface mp_add_seq_if #(
  parameter int unsigned OPW = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [OPW-1:0] in_a;
  logic [OPW-1:0] in_b;
  logic           in_cin;
  logic           in_sub;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] out_sum;
  logic           out_cout;
  logic           out_ov_sgn;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ov_sgn
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ov_sgn
  );
endinterface

// File: rtl/n_bit_adder.sv
// Combinational WIDTH-bit adder with carry-in and two's-complement overflow flag.
module n_bit_adder #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             ov_sgn
);

  assign sum    = a + b + WIDTH'(cin);
  assign ov_sgn = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit chunk per clock, LSB first,
// carry rippled through a register between chunks.
module mp_add_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned CHUNKS = 4
) (
  input logic         clk,
  input logic         rst_n,
  mp_add_seq_if.slave bus
);

  localparam int unsigned OPW = WIDTH * CHUNKS;
  localparam int unsigned IW  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  seq_state_e      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [OPW-1:0]  a_q, a_d;
  logic [OPW-1:0]  b_q, b_d;
  logic [OPW-1:0]  res_q, res_d;
  logic            cout_q, cout_d;
  logic            ov_q, ov_d;
  logic            valid_q, valid_d;

  logic [WIDTH-1:0] a_chunk;
  logic [WIDTH-1:0] b_chunk;
  logic [WIDTH:0]   add_sum;
  logic             adder_ov_unused;
  logic             last_chunk;

  assign a_chunk    = a_q[idx_q*WIDTH +: WIDTH];
  assign b_chunk    = b_q[idx_q*WIDTH +: WIDTH];
  assign last_chunk = (idx_q == IW'(CHUNKS - 1));

  // Extra adder bit turns the chunk carry-out into the sum MSB
  n_bit_adder #(.WIDTH(WIDTH + 1)) u_adder (
    .a      ({1'b0, a_chunk}),
    .b      ({1'b0, b_chunk}),
    .cin    (carry_q),
    .sum    (add_sum),
    .ov_sgn (adder_ov_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    valid_d = valid_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is A + ~B + 1; the +1 enters as the initial carry
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          carry_d = bus.in_sub | bus.in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[idx_q*WIDTH +: WIDTH] = add_sum[WIDTH-1:0];
        carry_d = add_sum[WIDTH];
        if (last_chunk) begin
          cout_d  = add_sum[WIDTH];
          ov_d    = (a_q[OPW-1] == b_q[OPW-1]) && (add_sum[WIDTH-1] != a_q[OPW-1]);
          valid_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = rst_n & (state_q == ST_IDLE);
  assign bus.out_valid  = valid_q;
  assign bus.out_sum    = res_q;
  assign bus.out_cout   = cout_q;
  assign bus.out_ov_sgn = ov_q;

endmodule
